// File: rtl/cla_addsub_pipe_if.sv
// Valid/ready operand and result channel for the pipelined lookahead adder/subtractor.
interface cla_addsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead slice per stage,
// slice carry registered between stages, global stall on output backpressure.
module cla_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    cla_addsub_pipe_if.slave bus
);
    localparam int STAGES = WIDTH / GROUP;
    localparam int LAST   = STAGES - 1;

    // Flattened lookahead: each carry is an OR of generate terms gated by the
    // propagate chain above them, plus the fully propagated slice carry-in.
    function automatic logic [GROUP:0] cla_carries(
        input logic [GROUP-1:0] g,
        input logic [GROUP-1:0] p,
        input logic             c0
    );
        logic [GROUP:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < GROUP; i++) begin
            term = c0;
            for (int j = 0; j <= i; j++) term = term & p[j];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    logic             r_vld [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_s   [STAGES];
    logic             r_c   [STAGES];
    logic             r_ovf;

    logic             w_vld [STAGES];
    logic [WIDTH-1:0] w_a   [STAGES];
    logic [WIDTH-1:0] w_b   [STAGES];
    logic [WIDTH-1:0] w_s   [STAGES];
    logic             w_c   [STAGES];
    logic             w_cm  [STAGES];
    logic             w_adv;

    assign w_adv = !r_vld[LAST] | bus.out_ready;

    always_comb begin : slices
        logic [WIDTH-1:0] ta, tb, ts;
        logic             tc, tv;
        logic [GROUP-1:0] g, p;
        logic [GROUP:0]   cy;
        ta = '0; tb = '0; ts = '0; tc = 1'b0; tv = 1'b0;
        g  = '0; p  = '0; cy = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                ta = bus.a;
                tb = bus.sub ? ~bus.b : bus.b;
                tc = bus.sub | bus.cin;
                ts = '0;
                tv = bus.in_valid;
            end else begin
                ta = r_a[(k > 0) ? k - 1 : 0];
                tb = r_b[(k > 0) ? k - 1 : 0];
                tc = r_c[(k > 0) ? k - 1 : 0];
                ts = r_s[(k > 0) ? k - 1 : 0];
                tv = r_vld[(k > 0) ? k - 1 : 0];
            end
            g  = ta[k*GROUP +: GROUP] & tb[k*GROUP +: GROUP];
            p  = ta[k*GROUP +: GROUP] ^ tb[k*GROUP +: GROUP];
            cy = cla_carries(g, p, tc);
            ts[k*GROUP +: GROUP] = p ^ cy[GROUP-1:0];
            w_a[k]   = ta;
            w_b[k]   = tb;
            w_s[k]   = ts;
            w_c[k]   = cy[GROUP];
            w_cm[k]  = cy[GROUP-1];
            w_vld[k] = tv;
        end
    end

    // Stage boundary: every slice register shifts together on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_s[k]   <= '0;
                r_c[k]   <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= w_vld[k];
                r_a[k]   <= w_a[k];
                r_b[k]   <= w_b[k];
                r_s[k]   <= w_s[k];
                r_c[k]   <= w_c[k];
            end
            r_ovf <= w_cm[LAST] ^ w_c[LAST];
        end
    end

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_vld[LAST];
    assign bus.sum       = r_s[LAST];
    assign bus.cout      = r_c[LAST];
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: GROUP=4, 16 and 1 instances share one stimulus stream,
// each checked by its own scoreboard against an arithmetic reference model.
module tb_cla_addsub_pipe;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         t_vld, t_ordy, t_cin, t_sub;
    logic [W-1:0] t_a, t_b;

    cla_addsub_pipe_if #(.WIDTH(W)) if4 ();
    cla_addsub_pipe_if #(.WIDTH(W)) if16 ();
    cla_addsub_pipe_if #(.WIDTH(W)) if1 ();

    assign if4.in_valid  = t_vld;  assign if16.in_valid  = t_vld;  assign if1.in_valid  = t_vld;
    assign if4.a         = t_a;    assign if16.a         = t_a;    assign if1.a         = t_a;
    assign if4.b         = t_b;    assign if16.b         = t_b;    assign if1.b         = t_b;
    assign if4.cin       = t_cin;  assign if16.cin       = t_cin;  assign if1.cin       = t_cin;
    assign if4.sub       = t_sub;  assign if16.sub       = t_sub;  assign if1.sub       = t_sub;
    assign if4.out_ready = t_ordy; assign if16.out_ready = t_ordy; assign if1.out_ready = t_ordy;

    cla_addsub_pipe #(.WIDTH(W), .GROUP(4))  u_g4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    cla_addsub_pipe #(.WIDTH(W), .GROUP(16)) u_g16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    cla_addsub_pipe #(.WIDTH(W), .GROUP(1))  u_g1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    logic [2:0]   rdy, ovl;
    logic [W-1:0] osum [3];
    logic         ocy  [3];
    logic         oov  [3];
    assign rdy = {if1.in_ready, if16.in_ready, if4.in_ready};
    assign ovl = {if1.out_valid, if16.out_valid, if4.out_valid};
    assign osum[0] = if4.sum;  assign osum[1] = if16.sum;  assign osum[2] = if1.sum;
    assign ocy[0]  = if4.cout; assign ocy[1]  = if16.cout; assign ocy[2]  = if1.cout;
    assign oov[0]  = if4.ovf;  assign oov[1]  = if16.ovf;  assign oov[2]  = if1.ovf;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc_n = 0;
    int    oc0, first0, last0;
    int    lat_exp [3];
    string nm [3];
    logic [17:0] sb [3][64];
    int    wp [3];
    int    rp [3];

    // Reference: {ovf, cout, sum} from plain wide addition and sign rules.
    function automatic logic [17:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ci, input logic s);
        logic [W:0]   full;
        logic [W-1:0] bb;
        logic         ov;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s | ci)};
        ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {ov, full[W], full[W-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic flush();
        for (int d = 0; d < 3; d++) begin
            wp[d] = 0;
            rp[d] = 0;
        end
    endtask

    // One clock: log accepts into each scoreboard, retire and check delivered results.
    task automatic cyc();
        logic [17:0] e;
        #2;
        for (int d = 0; d < 3; d++) begin
            if (t_vld && rdy[d]) begin
                sb[d][wp[d] % 64] = model(t_a, t_b, t_cin, t_sub);
                wp[d]++;
            end
            if (ovl[d] && t_ordy) begin
                if (rp[d] == wp[d]) begin
                    chk({nm[d], " spurious out_valid"}, 32'(ovl[d]), 32'd0);
                end else begin
                    e = sb[d][rp[d] % 64];
                    rp[d]++;
                    chk({nm[d], " sb sum"},  32'(osum[d]), 32'(e[15:0]));
                    chk({nm[d], " sb cout"}, 32'(ocy[d]),  32'(e[16]));
                    chk({nm[d], " sb ovf"},  32'(oov[d]),  32'(e[17]));
                end
                if (d == 0) begin
                    if (oc0 == 0) first0 = cyc_n;
                    last0 = cyc_n;
                    oc0++;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic one(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic s,
                       input logic [W-1:0] es, input logic ec, input logic eo, input string tag);
        logic [2:0] seen;
        t_a = a; t_b = b; t_cin = ci; t_sub = s; t_vld = 1'b1; t_ordy = 1'b1;
        #1;
        chk({tag, " in_ready"}, 32'(rdy), 32'd7);
        cyc();
        t_vld = 1'b0;
        seen  = 3'b000;
        for (int n = 1; n <= 40 && seen != 3'b111; n++) begin
            for (int d = 0; d < 3; d++) begin
                if (!seen[d] && ovl[d]) begin
                    seen[d] = 1'b1;
                    chk({tag, " ", nm[d], " latency"}, n, lat_exp[d]);
                    chk({tag, " ", nm[d], " sum"},  32'(osum[d]), 32'(es));
                    chk({tag, " ", nm[d], " cout"}, 32'(ocy[d]),  32'(ec));
                    chk({tag, " ", nm[d], " ovf"},  32'(oov[d]),  32'(eo));
                end
            end
            if (seen != 3'b111) cyc();
        end
        for (int d = 0; d < 3; d++)
            if (!seen[d]) chk({tag, " ", nm[d], " timeout"}, 32'(seen[d]), 32'd1);
    endtask

    initial begin
        logic [W-1:0] s_sum;
        logic         s_cy;
        int           s0;
        nm[0] = "g4"; nm[1] = "g16"; nm[2] = "g1";
        lat_exp[0] = 4; lat_exp[1] = 1; lat_exp[2] = 16;
        t_vld = 1'b0; t_ordy = 1'b0; t_cin = 1'b0; t_sub = 1'b0; t_a = '0; t_b = '0;
        oc0 = 0; first0 = 0; last0 = 0;
        flush();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk({nm[d], " rst out_valid"}, 32'(ovl[d]), 32'd0);
            chk({nm[d], " rst sum"},       32'(osum[d]), 32'd0);
            chk({nm[d], " rst cout"},      32'(ocy[d]), 32'd0);
            chk({nm[d], " rst ovf"},       32'(oov[d]), 32'd0);
            chk({nm[d], " rst in_ready"},  32'(rdy[d]), 32'd1);
        end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed arithmetic cases
        one(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, "t1");
        one(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "t2a");
        one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "t2b");
        one(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "t3a");
        one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "t3b");

        // Back-to-back stream
        oc0 = 0;
        s0  = cyc_n;
        t_ordy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            t_a = 16'($urandom); t_b = 16'($urandom); t_cin = 1'($urandom); t_sub = 1'(i);
            t_vld = 1'b1;
            cyc();
        end
        t_vld = 1'b0;
        repeat (20) cyc();
        chk("stream count",   oc0, 8);
        chk("stream span",    last0 - first0 + 1, 8);
        chk("stream latency", first0 - s0, 4);

        // Backpressure mid-stream
        t_vld = 1'b1;
        for (int i = 0; i < 6; i++) begin
            t_a = 16'($urandom); t_b = 16'($urandom); t_cin = 1'($urandom); t_sub = 1'($urandom);
            cyc();
        end
        t_ordy = 1'b0;
        #1;
        s_sum = osum[0];
        s_cy  = ocy[0];
        chk("stall entry out_valid", 32'(ovl[0]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            t_a = 16'($urandom); t_b = 16'($urandom);
            cyc();
            chk("stall in_ready",  32'(rdy[0]),  32'd0);
            chk("stall out_valid", 32'(ovl[0]),  32'd1);
            chk("stall sum",       32'(osum[0]), 32'(s_sum));
            chk("stall cout",      32'(ocy[0]),  32'(s_cy));
        end
        t_ordy = 1'b1;
        t_vld  = 1'b0;
        repeat (30) cyc();
        for (int d = 0; d < 3; d++) chk({nm[d], " stall drained"}, rp[d], wp[d]);

        // Asynchronous reset with beats in flight
        t_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            t_a = 16'($urandom); t_b = 16'($urandom); t_cin = 1'($urandom); t_sub = 1'($urandom);
            cyc();
        end
        t_vld = 1'b0;
        chk("pre-reset g4 out_valid", 32'(ovl[0]), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk({nm[d], " async rst out_valid"}, 32'(ovl[d]),  32'd0);
            chk({nm[d], " async rst sum"},       32'(osum[d]), 32'd0);
        end
        flush();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        oc0 = 0;
        repeat (20) cyc();
        chk("no output after reset", oc0, 0);
        one(16'hABCD, 16'h1234, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0, "t5");

        // Random regression with random valid/ready
        for (int i = 0; i < 10000; i++) begin
            t_vld  = ($urandom_range(0, 3) != 0);
            t_ordy = ($urandom_range(0, 3) != 0);
            t_a    = 16'($urandom);
            t_b    = 16'($urandom);
            t_cin  = 1'($urandom);
            t_sub  = 1'($urandom);
            cyc();
        end
        t_vld  = 1'b0;
        t_ordy = 1'b1;
        repeat (30) cyc();
        for (int d = 0; d < 3; d++) chk({nm[d], " random drained"}, rp[d], wp[d]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
